user_cl_stream_alu: RTL
=======================

# user_cl_stream_alu

Parametrised FIFO-to-FIFO streaming processor that succeeds the single-word add-constant user block inside the custom-logic shell. Reads words from the input data FIFO, applies a runtime-selectable operation (ADD/SUB/XOR/PASS) with a runtime-loaded operand, and writes results to the output data FIFO at up to one word per cycle. A control FIFO pair sets mode, operand and enable, and reads back a processed-word counter.

## Interface
- DATA_WIDTH, 32, width of data and control words (≥ 8)
- RD_LATENCY, 1, cycles from `*_rd` to valid `*_din` on both input FIFOs (1..4)
- SKID_DEPTH, 4, result buffer entries; power of 2, ≥ RD_LATENCY+2
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- data_empty  in  1  input data FIFO empty
- data_rd  out  1  input data FIFO read strobe
- data_din  in  DATA_WIDTH  input data word
- data_full  in  1  output data FIFO full
- data_wr  out  1  output data FIFO write strobe
- data_dout  out  DATA_WIDTH  output data word
- ctrl_empty  in  1  command FIFO empty
- ctrl_rd  out  1  command FIFO read strobe
- ctrl_din  in  DATA_WIDTH  command word
- ctrl_full  in  1  response FIFO full
- ctrl_wr  out  1  response FIFO write strobe
- ctrl_dout  out  DATA_WIDTH  response word

## Operation
- Reset values: all strobes 0, data_dout 0, ctrl_dout 0, mode ADD, operand 2, enable 1, count 0, skid empty, in-flight 0.
- Command word: opcode = ctrl_din[W-1:W-4], imm = ctrl_din[W-5:0] zero-extended. Opcodes: 0 NOP; 1 SET_MODE (imm[1:0]: 0 ADD, 1 SUB, 2 XOR, 3 PASS); 2 SET_OPERAND; 3 READ_COUNT (one response = count); 4 CLEAR_COUNT; 5 ENABLE (imm[0]). Other opcodes: consumed, no effect, no response.
- Result: ADD din+operand, SUB din−operand, both mod 2^W; XOR din^operand; PASS din.
- Data issue: data_rd=1 when enable, !data_empty, control FSM in C_IDLE, and skid occupancy + in-flight < SKID_DEPTH. In-flight tracked by RD_LATENCY-deep valid shift register.
- Output: data_wr = !skid_empty && !data_full (combinational); data_dout = skid head. Never writes while data_full=1.
- count increments on every cycle data_wr=1; wraps 2^W−1 → 0.
- Control FSM: C_IDLE → (ctrl_empty=0: ctrl_rd=1 one cycle) C_FETCH → (RD_LATENCY cycles, capture command) C_DRAIN → (in-flight=0 and skid empty) C_EXEC → apply; READ_COUNT → C_RESP, else C_IDLE. C_RESP: ctrl_wr=1 with ctrl_dout=count in first cycle ctrl_full=0, then C_IDLE.
- Draining before execute makes every command apply exactly between words: words read before ctrl_rd use old settings, words read after use new.
- ENABLE=0 stops new reads only; buffered words still drain. While stalled by data_full with enable=1, reads stop at skid capacity; no word is lost or duplicated.
- Reset mid-operation: everything returns to reset values immediately; in-flight FIFO data is discarded.

## Timing
- data_rd in cycle T → data_din sampled end of T+RD_LATENCY → earliest data_wr in T+RD_LATENCY+1 (latency RD_LATENCY+1).
- Sustained throughput 1 word/cycle when data_full=0 and data_empty=0.
- Command latency: ctrl_rd in cycle T → settings active at T+RD_LATENCY+1 plus drain time.
- READ_COUNT with empty pipeline: ctrl_wr at T+RD_LATENCY+2 if ctrl_full=0.
- Only one command in flight; ctrl_rd never asserted outside C_IDLE.

## Structure
- Package user_cl_pkg: opcode and mode localparams, opcode/imm field positions, reset operand constant (2).
- Sub-module user_cl_skid_fifo: synchronous FIFO, DATA_WIDTH × SKID_DEPTH, push/pop/empty/count, async active-high reset.
- Top holds issue logic, in-flight shift register, ALU, counter, control FSM.

## Test plan
- Reset defaults: push 5, 0xFFFFFFFF → outputs 7, 0x00000001; latency RD_LATENCY+1 from data_rd.
- Mode/operand: SET_OPERAND 0x10, SET_MODE SUB, push 3 → 0xFFFFFFF3; SET_MODE XOR, push 0xFF → 0xEF; PASS, push 0x1234 → 0x1234.
- Backpressure: stream 16 words 0..15 with data_full held 1 for 20 cycles mid-stream → output 2..17 in order, no loss/duplication, data_rd stops at SKID_DEPTH outstanding.
- Command ordering: push 4 words, then SET_OPERAND 0, then 4 more → first 4 get +2, last 4 unchanged.
- Counter: process 10 words, READ_COUNT → response 10 held until ctrl_full drops; CLEAR_COUNT, READ_COUNT → 0.
- Reset mid-stream: assert reset with 3 words in skid and 1 in flight → all strobes 0 same cycle, post-reset stream resumes with operand 2, count 0.

Source files
------------

// File: rtl/user_cl_pkg.sv
// Shared definitions for the custom-logic streaming ALU.
//   - command opcodes and ALU mode encodings
//   - command field layout (opcode in the top OPC_BITS bits, immediate below)
//   - reset value of the runtime operand
//   - control FSM state type
package user_cl_pkg;

    localparam int OPC_BITS = 4;

    localparam logic [OPC_BITS-1:0] OP_NOP         = 4'd0;
    localparam logic [OPC_BITS-1:0] OP_SET_MODE    = 4'd1;
    localparam logic [OPC_BITS-1:0] OP_SET_OPERAND = 4'd2;
    localparam logic [OPC_BITS-1:0] OP_READ_COUNT  = 4'd3;
    localparam logic [OPC_BITS-1:0] OP_CLEAR_COUNT = 4'd4;
    localparam logic [OPC_BITS-1:0] OP_ENABLE      = 4'd5;

    localparam logic [1:0] MODE_ADD  = 2'd0;
    localparam logic [1:0] MODE_SUB  = 2'd1;
    localparam logic [1:0] MODE_XOR  = 2'd2;
    localparam logic [1:0] MODE_PASS = 2'd3;

    localparam int OPERAND_RST = 2;

    typedef enum logic [2:0] {
        C_IDLE,
        C_FETCH,
        C_DRAIN,
        C_EXEC,
        C_RESP
    } ctrl_state_t;

endpackage

// File: rtl/user_cl_skid_fifo.sv
// Result buffer between the ALU and the output data FIFO.
// Ports:
//   clock, reset      sole clock, asynchronous active-high reset
//   push, push_data   write one word (caller guarantees not full)
//   pop               drop the head word (caller guarantees not empty)
//   head              current head word
//   empty, count      occupancy status
module user_cl_skid_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_WIDTH-1:0]    push_data,
    input  logic                     pop,
    output logic [DATA_WIDTH-1:0]    head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    import user_cl_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: head is only consumed when count is non-zero.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/user_cl_stream_alu.sv
// FIFO-to-FIFO streaming ALU with a command/response control channel.
// Words from the input data FIFO get ADD/SUB/XOR/PASS with a runtime operand
// and are written to the output data FIFO, up to one word per cycle.
// Ports:
//   clock, reset                       sole clock, asynchronous active-high reset
//   data_empty, data_rd, data_din      input data FIFO (RD_LATENCY read latency)
//   data_full, data_wr, data_dout      output data FIFO
//   ctrl_empty, ctrl_rd, ctrl_din      command FIFO (RD_LATENCY read latency)
//   ctrl_full, ctrl_wr, ctrl_dout      response FIFO
//
// Control FSM:
//   state   | meaning
//   C_IDLE  | data may issue; a pending command is read here
//   C_FETCH | waiting RD_LATENCY cycles for the command word, captured on last
//   C_DRAIN | waiting for in-flight reads and the result buffer to empty
//   C_EXEC  | apply the captured command
//   C_RESP  | present the count response until the response FIFO accepts it
module user_cl_stream_alu
    import user_cl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int SKID_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  data_empty,
    output logic                  data_rd,
    input  logic [DATA_WIDTH-1:0] data_din,
    input  logic                  data_full,
    output logic                  data_wr,
    output logic [DATA_WIDTH-1:0] data_dout,
    input  logic                  ctrl_empty,
    output logic                  ctrl_rd,
    input  logic [DATA_WIDTH-1:0] ctrl_din,
    input  logic                  ctrl_full,
    output logic                  ctrl_wr,
    output logic [DATA_WIDTH-1:0] ctrl_dout
);

    localparam int CNT_W = $clog2(SKID_DEPTH) + 1;
    localparam int IMM_W = DATA_WIDTH - OPC_BITS;
    localparam int TMR_W = 2;

    ctrl_state_t state_q, state_d;

    logic [1:0]            mode_q;
    logic [DATA_WIDTH-1:0] operand_q;
    logic                  enable_q;
    logic [DATA_WIDTH-1:0] count_q;
    logic [DATA_WIDTH-1:0] cmd_q;
    logic [DATA_WIDTH-1:0] resp_q;
    logic [TMR_W-1:0]      fetch_tmr_q;
    logic [RD_LATENCY-1:0] inflight_q;

    logic [CNT_W-1:0]      inflight_cnt;
    logic [CNT_W-1:0]      skid_cnt;
    logic [CNT_W:0]        outstanding;
    logic                  skid_empty;
    logic [DATA_WIDTH-1:0] skid_head;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  data_rd_i;
    logic                  ctrl_rd_i;
    logic                  ctrl_wr_i;
    logic                  drained;

    logic [OPC_BITS-1:0]   cmd_op;
    logic [IMM_W-1:0]      cmd_imm;

    assign cmd_op  = cmd_q[DATA_WIDTH-1 -: OPC_BITS];
    assign cmd_imm = cmd_q[IMM_W-1:0];

    // ---------------- data path ----------------

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + CNT_W'(inflight_q[i]);
        end
    end

    // Reserve a skid slot for every read already issued so a full output FIFO
    // can never overflow the buffer.
    assign outstanding = {1'b0, skid_cnt} + {1'b0, inflight_cnt};
    assign data_rd_i   = enable_q && !data_empty && (state_q == C_IDLE)
                         && (outstanding < (CNT_W+1)'(SKID_DEPTH));
    assign drained     = (inflight_cnt == '0) && skid_empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight_q <= '0;
        end else begin
            inflight_q[0] <= data_rd_i;
            for (int i = 1; i < RD_LATENCY; i++) begin
                inflight_q[i] <= inflight_q[i-1];
            end
        end
    end

    always_comb begin
        case (mode_q)
            MODE_ADD: alu_result = data_din + operand_q;
            MODE_SUB: alu_result = data_din - operand_q;
            MODE_XOR: alu_result = data_din ^ operand_q;
            default:  alu_result = data_din;
        endcase
    end

    user_cl_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (SKID_DEPTH)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight_q[RD_LATENCY-1]),
        .push_data (alu_result),
        .pop       (data_wr),
        .head      (skid_head),
        .empty     (skid_empty),
        .count     (skid_cnt)
    );

    // Strobes are gated by reset so they drop in the same cycle reset rises.
    assign data_rd   = data_rd_i && !reset;
    assign data_wr   = !skid_empty && !data_full && !reset;
    assign data_dout = skid_empty ? '0 : skid_head;
    assign ctrl_rd   = ctrl_rd_i && !reset;
    assign ctrl_wr   = ctrl_wr_i && !reset;
    assign ctrl_dout = resp_q;

    // ---------------- control FSM ----------------

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= C_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        ctrl_rd_i = 1'b0;
        ctrl_wr_i = 1'b0;
        case (state_q)
            C_IDLE: begin
                if (!ctrl_empty) begin
                    ctrl_rd_i = 1'b1;
                    state_d   = C_FETCH;
                end
            end
            C_FETCH: begin
                // A pipeline that is already empty costs no drain cycle.
                if (fetch_tmr_q == '0) state_d = drained ? C_EXEC : C_DRAIN;
            end
            C_DRAIN: begin
                if (drained) state_d = C_EXEC;
            end
            C_EXEC: begin
                state_d = (cmd_op == OP_READ_COUNT) ? C_RESP : C_IDLE;
            end
            C_RESP: begin
                if (!ctrl_full) begin
                    ctrl_wr_i = 1'b1;
                    state_d   = C_IDLE;
                end
            end
            default: state_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_tmr_q <= '0;
            cmd_q       <= '0;
        end else begin
            if (ctrl_rd_i) begin
                fetch_tmr_q <= TMR_W'(RD_LATENCY - 1);
            end else if (state_q == C_FETCH && fetch_tmr_q != '0) begin
                fetch_tmr_q <= fetch_tmr_q - TMR_W'(1);
            end
            if (state_q == C_FETCH && fetch_tmr_q == '0) cmd_q <= ctrl_din;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q    <= MODE_ADD;
            operand_q <= DATA_WIDTH'(OPERAND_RST);
            enable_q  <= 1'b1;
            count_q   <= '0;
            resp_q    <= '0;
        end else begin
            if (data_wr) count_q <= count_q + DATA_WIDTH'(1);
            if (state_q == C_EXEC) begin
                case (cmd_op)
                    OP_SET_MODE:    mode_q    <= cmd_imm[1:0];
                    OP_SET_OPERAND: operand_q <= {{OPC_BITS{1'b0}}, cmd_imm};
                    OP_READ_COUNT:  resp_q    <= count_q;
                    OP_CLEAR_COUNT: count_q   <= '0;
                    OP_ENABLE:      enable_q  <= cmd_imm[0];
                    default:        ;
                endcase
            end
        end
    end

endmodule
